// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: turns a bare frame byte burst into a GMII wire frame
// (preamble, SFD, data, zero pad, CRC-32 FCS, inter-frame gap).
// Ports:
//   clk_125      framer clock
//   i_rst        synchronous reset, active-high
//   i_qbu_data   frame byte; i_qbu_valid marks one contiguous burst per frame
//   o_gmii_txd   registered wire byte; o_gmii_tx_en registered byte valid
//   o_busy       FSM active or FIFO holding bytes
//   o_overflow   sticky: a byte was dropped on a full FIFO
module gmii_tx_framer #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned IFG_LEN    = 12,
  parameter int unsigned MIN_LEN    = 60,
  parameter bit          PAD_EN     = 1'b1
) (
  input  logic       clk_125,
  input  logic       i_rst,
  input  logic [7:0] i_qbu_data,
  input  logic       i_qbu_valid,
  output logic [7:0] o_gmii_txd,
  output logic       o_gmii_tx_en,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(IFG_LEN + 8);
  localparam int unsigned BW = 7;
  localparam logic [BW-1:0] BCNT_MAX = '1;
  localparam logic [31:0]   CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [31:0]     crc_q, crc_d;
  logic            last_q, last_d;
  logic [7:0]      txd_q, txd_d;
  logic            tx_en_q, tx_en_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            stg_vld_q, stg_vld_d;
  logic [7:0]      stg_data_q, stg_data_d;
  logic            armed_q, armed_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [8:0]      mem_q [FIFO_DEPTH];

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            wr_en;
  logic            drop;
  logic [8:0]      head;
  logic [31:0]     fcs_word;

  // Reflected CRC-32, one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Input stage; after reset, capture waits until valid has been seen low.
  always_comb begin
    stg_vld_d  = i_qbu_valid && armed_q;
    stg_data_d = i_qbu_data;
    armed_d    = armed_q || !i_qbu_valid;
  end

  // FIFO bookkeeping; a pop frees the slot for a same-cycle write when full.
  always_comb begin
    fifo_empty = (fcnt_q == '0);
    fifo_full  = (fcnt_q == CW'(FIFO_DEPTH));
    pop        = (state_d == S_DATA);
    wr_en      = stg_vld_q && (!fifo_full || pop);
    drop       = stg_vld_q && fifo_full && !pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fcnt_d     = fcnt_q + CW'(wr_en) - CW'(pop);
    ovf_d      = ovf_q || drop;
    head       = mem_q[rd_ptr_q];
  end

  // FSM; state_q always describes the byte currently on o_gmii_txd.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + TW'(1);
    bcnt_d   = bcnt_q;
    crc_d    = crc_q;
    last_d   = last_q;
    txd_d    = 8'h00;
    tx_en_d  = 1'b0;
    fcs_word = ~crc_q;

    unique case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_PRE;
      S_PRE:  if (tmr_q == TW'(6)) state_d = S_SFD;
      S_SFD:  state_d = S_DATA;
      S_DATA: begin
        if (last_q) begin
          state_d = (PAD_EN && (bcnt_q < BW'(MIN_LEN))) ? S_PAD : S_FCS;
        end
      end
      S_PAD:  if (bcnt_q >= BW'(MIN_LEN)) state_d = S_FCS;
      S_FCS:  if (tmr_q == TW'(3)) state_d = S_IFG;
      // Going straight to PRE keeps the gap at exactly IFG_LEN idle cycles.
      S_IFG:  if (tmr_q == TW'(IFG_LEN - 1)) state_d = fifo_empty ? S_IDLE : S_PRE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tmr_d = '0;

    case (state_d)
      S_PRE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        tx_en_d = 1'b1;
        bcnt_d  = '0;
        crc_d   = 32'hFFFF_FFFF;
      end
      S_DATA: begin
        txd_d   = head[7:0];
        tx_en_d = 1'b1;
        last_d  = head[8];
        bcnt_d  = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BW'(1);
        crc_d   = crc_byte(crc_q, head[7:0]);
      end
      S_PAD: begin
        tx_en_d = 1'b1;
        bcnt_d  = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BW'(1);
        crc_d   = crc_byte(crc_q, 8'h00);
      end
      S_FCS: begin
        txd_d   = fcs_word[{tmr_d[1:0], 3'b000} +: 8];
        tx_en_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d != S_IDLE) || (fcnt_d != '0);
  end

  always_ff @(posedge clk_125) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bcnt_q     <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      last_q     <= 1'b0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= 8'h00;
      armed_q    <= !i_qbu_valid;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bcnt_q     <= bcnt_d;
      crc_q      <= crc_d;
      last_q     <= last_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      armed_q    <= armed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Entry tag: last=1 when the burst ended right after the staged byte.
  always_ff @(posedge clk_125) begin
    if (!i_rst && wr_en) begin
      mem_q[wr_ptr_q] <= {!i_qbu_valid, stg_data_q};
    end
  end

  assign o_gmii_txd   = txd_q;
  assign o_gmii_tx_en = tx_en_q;
  assign o_busy       = busy_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: one unpadded instance with a 32-entry FIFO and
// one padded instance with the default 64-entry FIFO, sharing clock/reset.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] drv_data = 8'h00;
  logic       drv_valid = 1'b0;
  logic       sel = 1'b0;

  logic       v0, v1;
  logic [7:0] txd0, txd1;
  logic       en0, en1, busy0, busy1, ov0, ov1;
  logic [7:0] txd_m;
  logic       en_m, busy_m, ov_m;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         exp_len_q[$];

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v0     = drv_valid & ~sel;
  assign v1     = drv_valid & sel;
  assign txd_m  = sel ? txd1 : txd0;
  assign en_m   = sel ? en1 : en0;
  assign busy_m = sel ? busy1 : busy0;
  assign ov_m   = sel ? ov1 : ov0;

  gmii_tx_framer #(.FIFO_DEPTH(32), .IFG_LEN(12), .MIN_LEN(60), .PAD_EN(1'b0)) u_nopad (
    .clk_125(clk), .i_rst(rst), .i_qbu_data(drv_data), .i_qbu_valid(v0),
    .o_gmii_txd(txd0), .o_gmii_tx_en(en0), .o_busy(busy0), .o_overflow(ov0)
  );

  gmii_tx_framer #(.FIFO_DEPTH(64), .IFG_LEN(12), .MIN_LEN(60), .PAD_EN(1'b1)) u_pad (
    .clk_125(clk), .i_rst(rst), .i_qbu_data(drv_data), .i_qbu_valid(v1),
    .o_gmii_txd(txd1), .o_gmii_tx_en(en1), .o_busy(busy1), .o_overflow(ov1)
  );

  // The FIFO must never be popped empty while sending data.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(u_pad.pop && u_pad.fifo_empty)) else $error("FAIL underrun u_pad popped empty FIFO");
      assert (!(u_nopad.pop && u_nopad.fifo_empty)) else $error("FAIL underrun u_nopad popped empty FIFO");
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [7:0] fbyte(input int seed, input int i);
    if (seed == 0) return 8'(32'h31 + i);
    return 8'(i * 37 + seed * 101 + (i >> 4));
  endfunction

  task automatic push_frame(input int n, input int seed, input bit pad);
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    tot = (pad && n < 60) ? 60 : n;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? fbyte(seed, i) : 8'h00;
      exp_q.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    exp_len_q.push_back(8 + tot + 4);
  endtask

  task automatic drive_frame(input int n, input int seed, output int t0);
    t0 = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drv_data  = fbyte(seed, i);
      drv_valid = 1'b1;
      if (i == 0) t0 = cyc;
    end
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  // Waits for the next frame on the selected DUT and checks it byte by byte.
  task automatic collect_frame(input string name, output int first_c, output int last_c);
    int         len;
    int         waited;
    logic [7:0] e;
    first_c = -1;
    last_c  = -1;
    waited  = 0;
    @(negedge clk);
    while (en_m !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    len = exp_len_q.pop_front();
    n_run++;
    if (en_m !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: tx_en=%b expected 1 within 3000 cycles", name, en_m);
      for (int i = 0; i < len; i++) e = exp_q.pop_front();
      return;
    end
    first_c = cyc;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (en_m !== 1'b1 || txd_m !== e) begin
        n_fail++;
        $display("FAIL %s byte %0d: txd=%h en=%b expected txd=%h en=1", name, i, txd_m, en_m, e);
      end
    end
    last_c = cyc;
    @(negedge clk);
    n_run++;
    if (en_m !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: tx_en=%b expected 0 after %0d bytes", name, en_m, len);
    end
  endtask

  task automatic check_latency(input string name, input int first_c, input int t0);
    n_run++;
    if (first_c - t0 !== 3) begin
      n_fail++;
      $display("FAIL %s latency: first preamble at T0+%0d expected T0+3", name, first_c - t0);
    end
  endtask

  task automatic check_idle(input string name);
    repeat (20) @(negedge clk);
    n_run++;
    if (busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b expected 0", name, busy_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_run++;
    if ({txd0, en0, busy0, ov0} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_nopad: txd=%h en=%b busy=%b ovf=%b expected 00 0 0 0", txd0, en0, busy0, ov0);
    end
    n_run++;
    if ({txd1, en1, busy1, ov1} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_pad: txd=%h en=%b busy=%b ovf=%b expected 00 0 0 0", txd1, en1, busy1, ov1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({en0, busy0, en1, busy1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: en0=%b busy0=%b en1=%b busy1=%b expected all 0", en0, busy0, en1, busy1);
    end
  endtask

  task automatic test_crc_nopad();
    logic [7:0] fcs [4];
    int t0, f, l;
    sel = 1'b0;
    fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[i]);
    exp_len_q.push_back(21);
    fork
      drive_frame(9, 0, t0);
      collect_frame("crc_nopad", f, l);
    join
    check_latency("crc_nopad", f, t0);
    check_idle("crc_nopad");
  endtask

  task automatic test_overflow();
    sel = 1'b0;
    @(negedge clk);
    n_run++;
    if (ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_initial: ovf=%b expected 0", ov0);
    end
    // 1-byte frames drain one per 25 cycles; write 35 hits a full FIFO at T0+71.
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      drv_data  = 8'(k);
      drv_valid = 1'b1;
      @(negedge clk);
      if (k == 36) begin
        n_run++;
        if (ov0 !== 1'b1) begin
          n_fail++;
          $display("FAIL overflow_rise: ovf=%b at T0+72 expected 1", ov0);
        end
      end
      @(posedge clk); #1;
      drv_valid = 1'b0;
      @(negedge clk);
      if (k == 35) begin
        n_run++;
        if (ov0 !== 1'b0) begin
          n_fail++;
          $display("FAIL overflow_early: ovf=%b at T0+71 expected 0", ov0);
        end
      end
    end
    repeat (300) @(negedge clk);
    n_run++;
    if (ov0 !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: ovf=%b expected 1", ov0);
    end
  endtask

  task automatic test_pad();
    int t0, f, l;
    sel = 1'b1;
    push_frame(14, 3, 1'b1);
    fork
      drive_frame(14, 3, t0);
      collect_frame("pad14", f, l);
    join
    check_latency("pad14", f, t0);
    check_idle("pad14");
  endtask

  task automatic test_back_to_back();
    int ta, tb, fa, la, fb, lb;
    sel = 1'b1;
    push_frame(64, 5, 1'b1);
    push_frame(64, 6, 1'b1);
    fork
      begin
        drive_frame(64, 5, ta);
        drive_frame(64, 6, tb);
      end
      begin
        collect_frame("b2b_first", fa, la);
        collect_frame("b2b_second", fb, lb);
      end
    join
    check_latency("b2b_first", fa, ta);
    n_run++;
    if (fb - la - 1 !== 12) begin
      n_fail++;
      $display("FAIL b2b_gap: idle gap %0d cycles expected 12", fb - la - 1);
    end
    n_run++;
    if (ov1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overflow: ovf=%b expected 0", ov1);
    end
    check_idle("b2b");
  endtask

  task automatic test_max_len();
    int t0, f, l;
    sel = 1'b1;
    push_frame(1514, 7, 1'b1);
    fork
      drive_frame(1514, 7, t0);
      collect_frame("max1514", f, l);
    join
    check_latency("max1514", f, t0);
    n_run++;
    if (ov1 !== 1'b0) begin
      n_fail++;
      $display("FAIL max1514_overflow: ovf=%b expected 0", ov1);
    end
    check_idle("max1514");
  endtask

  task automatic test_reset_mid_data();
    int t0, f, l, waited, seen;
    sel = 1'b1;
    fork
      drive_frame(100, 9, t0);
      begin
        waited = 0;
        @(negedge clk);
        while (en_m !== 1'b1 && waited < 100) begin
          @(negedge clk);
          waited++;
        end
        repeat (26) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_run++;
        if (en_m !== 1'b1 || txd_m !== fbyte(9, 19)) begin
          n_fail++;
          $display("FAIL rst_byte20: txd=%h en=%b expected txd=%h en=1", txd_m, en_m, fbyte(9, 19));
        end
        @(negedge clk);
        n_run++;
        if ({txd_m, en_m, busy_m} !== 10'h000) begin
          n_fail++;
          $display("FAIL rst_mid_data: txd=%h en=%b busy=%b expected 00 0 0", txd_m, en_m, busy_m);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (110) begin
          @(negedge clk);
          if (en_m !== 1'b0 || busy_m !== 1'b0) seen++;
        end
        n_run++;
        if (seen != 0) begin
          n_fail++;
          $display("FAIL rst_discard: %0d active cycles after release expected 0", seen);
        end
      end
    join
    push_frame(30, 10, 1'b1);
    fork
      drive_frame(30, 10, t0);
      collect_frame("rst_clean", f, l);
    join
    check_latency("rst_clean", f, t0);
    check_idle("rst_clean");
  endtask

  initial begin
    test_reset();
    test_crc_nopad();
    test_overflow();
    test_pad();
    test_back_to_back();
    test_max_len();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
